// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits needed to represent the largest w-bit unsigned value.
  function automatic int min_digits(input int w);
    longint unsigned v;
    int              d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction step: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative (one bit per clock) binary-to-BCD converter with valid/ready on both sides.
// Define BIN2BCD_SEQ_BLANK_EN to generate the registered leading-zero mask on lead_blank.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic [DIGITS-1:0]             lead_blank
);

  localparam int BW    = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = ceil_log2(W + 1);

  generate
    if (W < 4 || W > 32) begin : g_bad_width
      $error("bin2bcd_seq: W=%0d outside 4..32", W);
    end
    if (DIGITS < min_digits(W)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS=%0d too small for W=%0d", DIGITS, W);
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_sr;
  logic [BW-1:0]    r_acc;
  logic [BW-1:0]    r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_acc_shift;
  logic             w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_acc[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Top accumulator bit falls off here; DIGITS guarantees it is always zero.
  assign w_acc_shift = {w_adj[BW-2:0], r_sr[W-1]};
  assign w_last      = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == SHIFT) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr  <= bin;
            r_acc <= '0;
            r_cnt <= CNT_W'(W);
          end
        end
        SHIFT: begin
          r_sr  <= {r_sr[W-2:0], 1'b0};
          r_acc <= w_acc_shift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) r_bcd <= w_acc_shift;
        end
        default: ;
      endcase
    end
  end

  assign bcd = r_bcd;

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  // Digit k is blank when it and every digit above it are zero; the ones digit never is.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_ones
        assign w_blank_next[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank_next[gi] = (w_acc_shift[BW-1:gi*BCD_DIGIT_W] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_blank <= '0;
    else if (r_state == SHIFT && w_last)  r_blank <= w_blank_next;
  end

  assign lead_blank = r_blank;
`else
  assign lead_blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

  localparam int TW = 16;
  localparam int TD = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [TW-1:0]     bin = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [4*TD-1:0]   bcd;
  logic              busy;
  logic [TD-1:0]     lead_blank;

  logic              s_in_valid = 1'b0;
  logic              s_in_ready;
  logic [7:0]        s_bin = '0;
  logic              s_out_valid;
  logic              s_out_ready = 1'b0;
  logic [11:0]       s_bcd;
  logic              s_busy;
  logic [2:0]        s_lead_blank;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [63:0]       last_bcd = '0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(TW), .DIGITS(TD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .busy(busy),
    .lead_blank(lead_blank)
  );

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin(s_bin),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .bcd(s_bcd), .busy(s_busy),
    .lead_blank(s_lead_blank)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input longint unsigned v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r = r | (64'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] blank_model(input longint unsigned v, input int nd);
    logic [63:0]     r;
    longint unsigned p;
    r = '0;
`ifdef BIN2BCD_SEQ_BLANK_EN
    p = 10;
    for (int k = 1; k < nd; k++) begin
      if (v < p) r[k] = 1'b1;
      p = p * 10;
    end
`else
    p = 0;
    if (p != 0) r = '1;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"},  in_ready,   1);
    check_val({tag, "_out_valid"}, out_valid,  0);
    check_val({tag, "_busy"},      busy,       0);
    check_val({tag, "_bcd"},       bcd,        0);
    check_val({tag, "_blank"},     lead_blank, 0);
  endtask

  // One full transaction: hold = cycles out_ready stays low in DONE; junk is driven on bin
  // (and pulsed/held on in_valid) while the converter is busy.
  task automatic convert(input logic [TW-1:0] value, input int hold, input bit keep_valid,
                         input logic [TW-1:0] junk);
    int          lat;
    int          waited;
    logic [63:0] exp_bcd;
    logic [63:0] exp_blank;
    exp_bcd   = to_bcd(64'(value), TD);
    exp_blank = blank_model(64'(value), TD);
    bin       = value;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    waited    = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_val("accept_ready", in_ready, 1);
    tick();
    in_valid = keep_valid;
    bin      = junk;
    lat      = 0;
    while (!out_valid && lat < TW + 4) begin
      check_val("shift_in_ready", in_ready, 0);
      check_val("shift_busy", busy, 1);
      check_val("shift_bcd_held", bcd, last_bcd);
      tick();
      in_valid = keep_valid | lat[0];
      lat++;
    end
    check_val("latency", lat, TW);
    check_val("bcd", bcd, exp_bcd);
    check_val("lead_blank", lead_blank, exp_blank);
    check_val("done_in_ready", in_ready, 0);
    for (int c = 0; c < hold; c++) begin
      in_valid = keep_valid | c[0];
      tick();
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_bcd", bcd, exp_bcd);
    end
    out_ready = 1'b1;
    tick();
    check_val("post_hs_out_valid", out_valid, 0);
    check_val("post_hs_in_ready", in_ready, 1);
    out_ready = 1'b0;
    if (!keep_valid) in_valid = 1'b0;
    last_bcd = exp_bcd;
    $display("conv bin=%0d hold=%0d exp_bcd=%0h exp_blank=%b latency=%0d",
             value, hold, exp_bcd, exp_blank[TD-1:0], lat);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    convert(16'hFFFF, 0, 1'b0, 16'h1234);
    convert(16'd0, 0, 1'b1, 16'd9999);
    convert(16'd9999, 0, 1'b0, 16'd0);
    convert(16'd1234, 5, 1'b0, 16'd77);
    tick();
    check_val("no_capture_77", in_ready, 1);
    convert(16'd42, 1, 1'b0, 16'd5);
    convert(16'd0, 2, 1'b0, 16'd3);

    // Asynchronous reset during the 8th SHIFT cycle.
    bin      = 16'd40000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check_val("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    last_bcd = '0;
    for (int i = 0; i < TW + 2; i++) begin
      tick();
      check_val("after_rst_no_valid", out_valid, 0);
    end
    check_val("after_rst_ready", in_ready, 1);
    convert(16'd40000, 0, 1'b0, 16'd0);

    repeat (25) begin
      r = $urandom;
      convert(r[15:0], $urandom_range(0, 3), 1'b0, 16'($urandom));
    end

    // Narrow instance: W=8, DIGITS=3.
    s_bin       = 8'd255;
    s_in_valid  = 1'b1;
    s_out_ready = 1'b1;
    check_val("w8_ready", s_in_ready, 1);
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_val("w8_latency", lat, 8);
    check_val("w8_bcd", s_bcd, to_bcd(64'd255, 3));
    check_val("w8_blank", s_lead_blank, blank_model(64'd255, 3));
    tick();
    check_val("w8_post_hs_ready", s_in_ready, 1);
    $display("conv8 bin=255 exp_bcd=%0h latency=%0d", to_bcd(64'd255, 3), lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential, parametrised successor of the team's combinational binary-to-BCD converter.
- Converts a W-bit unsigned binary word to DIGITS packed BCD digits using iterative shift-and-add-3 (double dabble), one input bit per clock.
- Uses valid/ready handshakes on both sides.
- Sits between the time-measurement counter and the display/UART formatter in the wireless sender, where wide counts make a flat combinational converter too slow.

Parameters:
- W, 16, binary input width; legal range 4..32.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^W-1; elaboration fails otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bin is valid.
- in_ready  out  1  converter can accept a word; high only in IDLE.
- bin  in  W  unsigned binary operand.
- out_valid  out  1  bcd result valid.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- busy  out  1  high in SHIFT or DONE.
- lead_blank  out  DIGITS  leading-zero mask; see Optional Feature.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - bcd=0, lead_blank=0.
  - Internal shift register and bit counter cleared.
- States and transitions:
  - IDLE -> SHIFT on in_valid&&in_ready (the accept edge). bin is captured into the shift register; BCD accumulator cleared; counter=W.
  - SHIFT: on every edge, each 4-bit accumulator digit >=5 gets +3 (4-bit add, no carry between digits). The combined {accumulator, shift register} then shifts left 1, MSB of the binary first. Counter decrements. At counter==1 the last shift happens and the state goes to DONE.
  - DONE: out_valid=1; bcd is registered and held stable. On out_valid&&out_ready -> IDLE: out_valid drops and in_ready rises at the same edge.
- Latency:
  - out_valid is first high after exactly W rising edges following the accept edge.
  - Throughput is one conversion per W+2 cycles minimum.
  - No overlap: in_ready=0 throughout SHIFT and DONE.
- Width rules:
  - Accumulator is 4*DIGITS bits; bits shifted out of the top digit are discarded. This is unreachable given the DIGITS constraint.
  - Every output digit is 0..9.
- Boundary conditions:
  - bin=0 gives bcd=0.
  - bin=2^W-1 gives the full-scale decimal value.
  - in_valid asserted during SHIFT/DONE is ignored; the value is not captured.
  - out_ready held high before DONE: no effect until out_valid.
  - out_ready low in DONE: bcd and out_valid held indefinitely.
  - rst_n asserted mid-SHIFT or in DONE: immediate return to reset values; the partial result is lost and no out_valid pulse occurs.
- bcd changes only on the edge entering DONE. During SHIFT it keeps the previous result; the working accumulator is internal.

Optional Feature:
- Macro BIN2BCD_SEQ_BLANK_EN.
- Defined:
  - lead_blank is registered together with bcd on entering DONE.
  - Bit k=1 iff digit k and all higher digits are 0, with k>=1.
  - Bit 0 is always 0, so the ones digit is never blanked.
  - Blanking logic adds no cycles.
- Undefined: lead_blank is tied to 0 and no blanking logic is generated.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constant BCD_DIGIT_W=4.
  - Function min_digits(W), used for the DIGITS legality check.
  - Function ceil_log2 for the counter width ($clog2(W+1)).
- Sub-module bcd_digit_adj: combinational add-3-if-≥5 on one 4-bit digit; instantiated DIGITS times via generate.

Test Plan:
- W=16, DIGITS=5, bin=16'hFFFF with out_ready=1 -> bcd=20'h65535, out_valid high exactly 16 edges after accept, in_ready back high the edge after the handshake.
- bin=0, then bin=9999 back-to-back -> bcd=20'h00000, then 20'h09999. The second in_valid is held; it is accepted only once in_ready=1.
- bin=1234, out_ready low for 5 cycles in DONE -> bcd=20'h01234 and out_valid stable all 5 cycles; in_valid pulses with bin=77 during that time are not captured.
- rst_n pulsed low at the 8th SHIFT cycle of bin=40000 -> all outputs at reset values immediately. A new conversion of bin=40000 then gives 20'h40000 with normal latency.
- W=8, DIGITS=3, bin=255 -> bcd=12'h255 after 8 edges. DIGITS=2 with W=8 fails elaboration.
- With BIN2BCD_SEQ_BLANK_EN: bin=42 -> lead_blank=5'b11100; bin=0 -> 5'b11110. Without the macro: lead_blank=0 for both.
